// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: instruction formats, major opcodes and the
// immediate-source selector used by both the main decoder and the encoder.
package riscv_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_S = 2'd2;
    localparam logic [1:0] FMT_B = 2'd3;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    typedef enum logic [1:0] {
        IMMSRC_I = 2'b00,
        IMMSRC_S = 2'b01,
        IMMSRC_B = 2'b10,
        IMMSRC_J = 2'b11
    } immsrc_t;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_RUN,
        ENC_FULL
    } enc_state_t;

    // R-type carries no immediate; mapping it to I keeps the selector total.
    function automatic immsrc_t fmt_immsrc(input logic [1:0] fmt);
        case (fmt)
            FMT_S:   return IMMSRC_S;
            FMT_B:   return IMMSRC_B;
            default: return IMMSRC_I;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of decoded RV32I fields into one instruction word,
// plus a flag telling whether the immediate is representable in that format.
module instr_pack
    import riscv_pkg::*;
(
    input  logic        [1:0]  fmt,
    input  logic        [6:0]  opcode,
    input  logic        [2:0]  f3,
    input  logic        [6:0]  f7,
    input  logic        [4:0]  rd,
    input  logic        [4:0]  rs1,
    input  logic        [4:0]  rs2,
    input  logic signed [12:0] imm,
    output logic        [31:0] word,
    output logic               imm_ok
);

    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        if (fmt == FMT_R) begin
            word = {f7, rs2, rs1, f3, rd, opcode};
        end else begin
            case (fmt_immsrc(fmt))
                IMMSRC_S: begin
                    word   = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
                    imm_ok = (imm[12] == imm[11]);
                end
                // Branch offsets are halfword aligned; bit 0 has no slot in the word.
                IMMSRC_B: begin
                    word   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
                    imm_ok = ~imm[0];
                end
                default: begin
                    word   = {imm[11:0], rs1, f3, rd, opcode};
                    imm_ok = (imm[12] == imm[11]);
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Field-level instruction encoder: accepts decoded bundles over valid/ready and
// writes packed RV32I words sequentially into IMEM starting at address 0.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic        [1:0]  in_fmt,
    input  logic        [6:0]  in_opcode,
    input  logic        [2:0]  in_f3,
    input  logic        [6:0]  in_f7,
    input  logic        [4:0]  in_rd,
    input  logic        [4:0]  in_rs1,
    input  logic        [4:0]  in_rs2,
    input  logic signed [12:0] in_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic        [31:0] imem_wdata,
    output logic               done,
    output logic               full,
    output logic               err,
    output logic [ADDR_W:0]    count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    enc_state_t          state;
    logic [ADDR_W-1:0]   addr_p0;
    logic [31:0]         word_p0;
    logic                imm_ok_p0;
    logic                accept_p0;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [31:0]         wdata_p1;
    logic                done_p1;
    logic [ADDR_W:0]     count_p1;
    logic                full_p1;
    logic                err_p1;

    // Stage p0: handshake and combinational packing of the presented bundle
    assign in_ready  = (state == ENC_RUN) & ~start;
    assign accept_p0 = in_valid & in_ready;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .f3     (in_f3),
        .f7     (in_f7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .word   (word_p0),
        .imm_ok (imm_ok_p0)
    );

    // Stage p1: registered IMEM write port, counters and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ENC_IDLE;
            addr_p0  <= '0;
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            done_p1  <= 1'b0;
            count_p1 <= '0;
            full_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else if (start) begin
            state    <= ENC_RUN;
            addr_p0  <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            count_p1 <= '0;
            full_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            if (accept_p0) begin
                if (imm_ok_p0) begin
                    vld_p1   <= 1'b1;
                    addr_p1  <= addr_p0;
                    wdata_p1 <= word_p0;
                    count_p1 <= count_p1 + (ADDR_W+1)'(1);
                    // The cursor parks on the final word rather than wrapping.
                    if (addr_p0 == LAST_ADDR) begin
                        full_p1 <= 1'b1;
                    end else begin
                        addr_p0 <= addr_p0 + ADDR_W'(1);
                    end
                end else begin
                    err_p1 <= 1'b1;
                end
                if (in_last) begin
                    state   <= ENC_IDLE;
                    done_p1 <= 1'b1;
                end else if (imm_ok_p0 && (addr_p0 == LAST_ADDR)) begin
                    state <= ENC_FULL;
                end
            end
        end
    end

    assign imem_we    = vld_p1;
    assign imem_addr  = addr_p1;
    assign imem_wdata = wdata_p1;
    assign done       = done_p1;
    assign count      = count_p1;
    assign full       = full_p1;
    assign err        = err_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder, checked cycle by cycle
// against an arithmetic model of the RV32I word layout and program cursor.
module tb_instr_encoder;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } bun_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, in_valid, in_last;
    logic [1:0]  in_fmt;
    logic [6:0]  in_opcode, in_f7;
    logic [2:0]  in_f3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;

    logic        ra, wea, donea, fulla, erra;
    logic [7:0]  addra;
    logic [31:0] wda;
    logic [8:0]  cnta;
    logic        rb, web, doneb, fullb, errb;
    logic [1:0]  addrb;
    logic [31:0] wdb;
    logic [2:0]  cntb;

    instr_encoder #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(ra),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_f3(in_f3), .in_f7(in_f7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(wea), .imem_addr(addra), .imem_wdata(wda),
        .done(donea), .full(fulla), .err(erra), .count(cnta)
    );

    instr_encoder #(.IMEM_DEPTH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(rb),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_f3(in_f3), .in_f7(in_f7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(web), .imem_addr(addrb), .imem_wdata(wdb),
        .done(doneb), .full(fullb), .err(errb), .count(cntb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the selected encoder (sel=0: depth 256, sel=1: depth 4)
    bit          sel;
    int          depth;
    bit          m_run, m_err, m_full;
    int          m_addr, m_count;
    bit          e_we, e_done, e_rst;
    int          e_addr;
    logic [31:0] e_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int fld(input int v, input int lo, input int n);
        return (v >> lo) % (1 << n);
    endfunction

    function automatic void ref_enc(input bun_t b, output logic [31:0] w, output bit ok);
        int s, t;
        longint acc;
        s = (b.imm >= 13'd4096) ? int'(b.imm) - 8192 : int'(b.imm);
        t = int'(b.imm);
        acc = longint'(b.rs1) * (1 << 15) + longint'(b.f3) * (1 << 12) + longint'(b.op);
        case (b.fmt)
            2'd0: begin
                ok  = 1'b1;
                acc += longint'(b.f7) * (longint'(1) << 25) + longint'(b.rs2) * (1 << 20)
                     + longint'(b.rd) * (1 << 7);
            end
            2'd1: begin
                ok  = (s >= -2048) && (s <= 2047);
                acc += longint'(fld(t, 0, 12)) * (1 << 20) + longint'(b.rd) * (1 << 7);
            end
            2'd2: begin
                ok  = (s >= -2048) && (s <= 2047);
                acc += longint'(fld(t, 5, 7)) * (longint'(1) << 25) + longint'(b.rs2) * (1 << 20)
                     + longint'(fld(t, 0, 5)) * (1 << 7);
            end
            default: begin
                ok  = (s % 2 == 0);
                acc += longint'(fld(t, 12, 1)) * (longint'(1) << 31)
                     + longint'(fld(t, 5, 6)) * (longint'(1) << 25)
                     + longint'(b.rs2) * (1 << 20) + longint'(fld(t, 1, 4)) * (1 << 8)
                     + longint'(fld(t, 11, 1)) * (1 << 7);
            end
        endcase
        w = acc[31:0];
    endfunction

    function automatic bun_t mk(input int fmt, input int op, input int f3, input int f7,
                                input int rd, input int rs1, input int rs2, input int imm);
        bun_t b;
        b.fmt = 2'(fmt); b.op = 7'(op); b.f3 = 3'(f3); b.f7 = 7'(f7);
        b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = 13'(imm);
        return b;
    endfunction

    function automatic bun_t rnd_bundle();
        bun_t b;
        int s;
        b.fmt = 2'($urandom_range(0, 3));
        b.op  = (b.fmt == 2'd0) ? 7'h33 : (b.fmt == 2'd1) ? 7'h13 : (b.fmt == 2'd2) ? 7'h23 : 7'h63;
        b.f3  = 3'($urandom); b.f7 = 7'($urandom);
        b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            b.imm = 13'($urandom);
        end else begin
            s = int'($urandom_range(0, 4095)) - 2048;
            if (b.fmt == 2'd3) s = s - (s % 2);
            b.imm = 13'(s);
        end
        return b;
    endfunction

    task automatic cyc(input bun_t b, input bit v, input bit last, input bit st, input bit r);
        logic [31:0] w;
        bit ok, acc;
        in_fmt = b.fmt; in_opcode = b.op; in_f3 = b.f3; in_f7 = b.f7;
        in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm;
        in_valid = v; in_last = last; rst = r;
        start_a = st & ~sel; start_b = st & sel;
        #1;
        check("in_ready", 32'(sel ? rb : ra), 32'(m_run & ~st));
        ref_enc(b, w, ok);
        acc = v & m_run & ~st & ~r;
        e_we = 1'b0; e_done = 1'b0; e_rst = r;
        if (r) begin
            m_run = 0; m_addr = 0; m_count = 0; m_err = 0; m_full = 0;
            e_addr = 0; e_wdata = '0;
        end else if (st) begin
            m_run = 1; m_addr = 0; m_count = 0; m_err = 0; m_full = 0;
        end else if (acc) begin
            if (ok) begin
                e_we = 1'b1; e_addr = m_addr; e_wdata = w; m_count++;
                if (m_addr == depth - 1) begin
                    m_full = 1; m_run = 0;
                end else begin
                    m_addr++;
                end
            end else begin
                m_err = 1;
            end
            if (last) begin
                m_run = 0; e_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("imem_we", 32'(sel ? web : wea), 32'(e_we));
        check("done", 32'(sel ? doneb : donea), 32'(e_done));
        check("count", sel ? 32'(cntb) : 32'(cnta), 32'(m_count));
        check("full", 32'(sel ? fullb : fulla), 32'(m_full));
        check("err", 32'(sel ? errb : erra), 32'(m_err));
        if (e_we || e_rst) begin
            check("imem_addr", sel ? 32'(addrb) : 32'(addra), 32'(e_addr));
            check("imem_wdata", sel ? wdb : wda, e_wdata);
        end
    endtask

    bun_t nop;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(nop, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit v, last, st;
        nop = '0;
        sel = 1'b0; depth = 256;
        m_run = 0; m_err = 0; m_full = 0; m_addr = 0; m_count = 0;
        e_addr = 0; e_wdata = '0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = '0; in_opcode = '0; in_f3 = '0; in_f7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

        // Reset state on both instances
        cyc(nop, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(nop, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst4_ready", 32'(rb), 32'd0);
        check("rst4_count", 32'(cntb), 32'd0);

        // Depth-4 instance: stream five legal bundles with valid held high
        sel = 1'b1; depth = 4;
        cyc(nop, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(mk(1, 7'h13, 0, 0, i + 1, 0, 0, i + 10), 1'b1, 1'b0, 1'b0, 1'b0);
        check("d4_full", 32'(fullb), 32'd1);
        check("d4_ready", 32'(rb), 32'd0);
        cyc(nop, 1'b0, 1'b0, 1'b1, 1'b0);
        check("d4_full_clr", 32'(fullb), 32'd0);
        cyc(mk(1, 7'h13, 0, 0, 7, 0, 0, 99), 1'b1, 1'b0, 1'b0, 1'b0);
        check("d4_restart_addr", 32'(addrb), 32'd0);

        // Back to the depth-256 instance, which has been idle since reset
        sel = 1'b0; depth = 256;
        m_run = 0; m_err = 0; m_full = 0; m_addr = 0; m_count = 0;

        cyc(nop, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(mk(1, 7'h13, 0, 0, 1, 0, 0, 5), 1'b1, 1'b0, 1'b0, 1'b0);
        check("addi_word", wda, 32'h00500093);
        check("addi_count", 32'(cnta), 32'd1);

        cyc(nop, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(mk(0, 7'h33, 0, 0, 3, 1, 2, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        check("add_word", wda, 32'h002081B3);
        cyc(mk(2, 7'h23, 2, 0, 0, 1, 2, 8), 1'b1, 1'b1, 1'b0, 1'b0);
        check("sw_word", wda, 32'h0020A423);
        check("sw_addr", 32'(addra), 32'd1);
        check("sw_done", 32'(donea), 32'd1);
        idle(1);

        cyc(nop, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(mk(3, 7'h63, 0, 0, 0, 1, 2, 13'h1FFC), 1'b1, 1'b0, 1'b0, 1'b0);
        check("beq_word", wda, 32'hFE208EE3);
        cyc(mk(3, 7'h63, 0, 0, 0, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(mk(1, 7'h13, 0, 0, 4, 1, 0, 13'h800), 1'b1, 1'b0, 1'b0, 1'b0);
        check("illegal_err", 32'(erra), 32'd1);
        check("illegal_count", 32'(cnta), 32'd1);
        cyc(mk(1, 7'h13, 0, 0, 5, 1, 0, 7), 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_illegal_addr", 32'(addra), 32'd1);
        // Illegal bundle carrying last still ends the program
        cyc(mk(3, 7'h63, 0, 0, 0, 1, 2, 1), 1'b1, 1'b1, 1'b0, 1'b0);
        check("illegal_last_done", 32'(donea), 32'd1);
        idle(1);

        // Randomized traffic with occasional program ends and restarts
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 15) == 0);
            st   = m_run ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 2) == 0);
            cyc(rnd_bundle(), v, last, st, 1'b0);
        end

        // Reset the cycle after an acceptance drops the pending write
        cyc(nop, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(mk(1, 7'h13, 0, 0, 1, 0, 0, 5), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(mk(1, 7'h13, 0, 0, 2, 0, 0, 6), 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(mk(1, 7'h13, 0, 0, 2, 0, 0, 6), 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_we", 32'(wea), 32'd0);
        check("post_rst_ready", 32'(ra), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction-stream encoder for the single-cycle RV32I core: the inverse of the control/decode path. It accepts decoded instruction fields (format, opcode, funct3, funct7, register indices, immediate) over a valid/ready handshake. It packs each one into a 32-bit RV32I word and writes the words sequentially into instruction memory from address 0. The bench and boot path use it to build test programs in IMEM from field-level descriptions, and the decoder must reproduce the original fields from each word.

## Interface
Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words
- ADDR_W, 8, word-address width; must equal clog2(IMEM_DEPTH)

Ports:
- clk  input  1  system clock, rising edge. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; clears address/flags, enters RUN
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder accepts a bundle this cycle
- in_fmt  input  2  0=R, 1=I, 2=S, 3=B
- in_opcode  input  7  opcode field
- in_f3  input  3  funct3
- in_f7  input  7  funct7 (R only)
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_imm  input  13  signed immediate (byte offset for B)
- in_last  input  1  final bundle of the program
- imem_we  output  1  IMEM write strobe
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  encoded instruction
- done  output  1  one-cycle pulse after the last word is written
- full  output  1  IMEM exhausted; sticky until start/rst
- err  output  1  sticky illegal-immediate flag
- count  output  ADDR_W+1  words written since start

## Operation
- FSM states: IDLE, RUN, FULL.
  - IDLE to RUN on start.
  - RUN to IDLE on acceptance with in_last.
  - RUN to FULL when an accepted word takes the address IMEM_DEPTH-1 and in_last=0.
  - FULL to RUN on start.
  - start in any state: address=0, count=0, err=0, full=0, state=RUN.
- in_ready = (state==RUN) & ~start. In the start cycle, no bundle is accepted.
- Encoding:
  - R: {f7,rs2,rs1,f3,rd,opcode}
  - I: {imm[11:0],rs1,f3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],opcode}
  - Fields that a format does not use are ignored.
- Immediate legality:
  - I/S: imm[12]==imm[11], i.e. it fits 12-bit signed.
  - B: imm[0]==0.
  - R: always legal.
- Illegal bundle handling: the bundle is consumed (handshake completes). No IMEM write occurs, address and count do not advance, and err sets. in_last on an illegal bundle still ends the program (done pulses, state goes to IDLE).
- Legal bundle: written at the current address, then address and count increment by 1.
- Address never wraps. After a write to IMEM_DEPTH-1, full=1 and in_ready=0.
- Legal write with in_last to the final address: done pulses, state goes to IDLE, and full=1.

## Timing
- Bundle accepted at edge N: imem_we/imem_addr/imem_wdata are registered and valid for the cycle after N. The write completes at edge N+1.
- Throughput is 1 bundle/cycle. IMEM always accepts, so there is no backpressure from the write side.
- done asserts in the same cycle as the final imem_we, or in the cycle after acceptance if the final bundle was illegal.
- count/full/err update at edge N, visible in the cycle after N.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, full=0, err=0, count=0.
- rst mid-program: all of the above take effect at the next edge. An in-flight registered write is dropped (imem_we=0).
- rst and start together: rst wins.

## Structure
- Shared package riscv_pkg holds:
  - FMT_R/FMT_I/FMT_S/FMT_B constants
  - opcode constants: OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_S=0100011, OP_B=1100011
  - the immsrc encoding shared with the main decoder
- Sub-module instr_pack: purely combinational field-to-word packing plus an imm_ok output. The top level holds the FSM, address/count counters, output register and flags.

## Test plan
- start; then addi x1,x0,5 (I, op 0010011, imm=5, rd=1) -> imem_we at addr 0, wdata 0x00500093, count=1.
- add x3,x1,x2 (R, op 0110011) then sw x2,8(x1) (S, f3=010, last) -> addr 0: 0x002081B3; addr 1: 0x0020A423; done pulses with the second write; state IDLE.
- beq x1,x2,-4 (B, imm=0x1FFC) -> 0xFE208EE3.
- B with imm=3, then I with imm=0x800 (+2048) -> no writes, err=1, count unchanged; a following legal bundle writes to the unchanged address.
- IMEM_DEPTH=4: stream 5 legal bundles with in_valid held high -> 4 writes (addr 0..3), full=1 after the 4th, in_ready=0, and the 5th is not accepted. start -> full clears and address is 0.
- rst asserted the cycle after an acceptance -> no imem_we in the following cycle; all outputs at reset values; in_ready=0 until start.
